cpu_out_capture: RTL and testbench
==================================

Name: cpu_out_capture

Overview:
- Reader end of the CPU's 8-bit `z` result output.
- Samples `z` every clock and records each new value in an internal FIFO. The first value after capture is enabled is always recorded.
- Presents recorded values on a valid/ready read port to a host, display or UART path.
- Sits beside `CPU` at top level and in benches; it is how the team observes the program's output stream without cycle-matching the core.

Parameters:
- DEPTH, 16, FIFO entries; power of two, at least 2.
- AW, 4, pointer width; equals log2(DEPTH).
- TSW, 16, timestamp width; used only when CAP_TIMESTAMP_EN is defined.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  asynchronous active-low reset; 0 = reset asserted.
- z_in  in  8  CPU result output `z`.
- cap_en  in  1  1 = capture active.
- rd_ready  in  1  consumer accepts the head entry.
- rd_valid  out  1  head entry present.
- rd_data  out  8  head entry value.
- count  out  AW+1  number of stored entries, 0..DEPTH.
- overflow  out  1  sticky; a new value was dropped because the FIFO was full.
- clr_ovf  in  1  synchronous clear of `overflow`.

Behaviour:
- Reset (rst=0, async):
  - FSM to IDLE; pointers, count, last_z and overflow to 0.
  - rd_valid=0; rd_data=0; timestamp counter 0.
  - Reset mid-operation discards all stored entries.
- FSM states:
  - IDLE: no pushes. cap_en=1 moves to PRIME on the next edge.
  - PRIME: unconditional push of z_in; last_z<=z_in; go to TRACK. If cap_en=0 in this cycle, go to IDLE with no push.
  - TRACK: push when z_in != last_z; last_z<=z_in on every edge. cap_en=0 returns to IDLE on that edge with no push.
  - Re-enabling after IDLE passes through PRIME again, so the current value is always recorded once.
- Push timing:
  - Push condition is evaluated combinationally from z_in at edge n; the entry is written at edge n.
  - rd_valid/rd_data reflect it after edge n, i.e. 1-cycle latency when the FIFO was empty.
  - No combinational bypass.
- Pop: on the rising edge with rd_valid & rd_ready, advance the read pointer. rd_data is the head entry, combinational from the storage array.
- Full:
  - A push attempt with count==DEPTH and no pop in the same cycle is dropped and sets overflow=1.
  - last_z still updates, so one drop is recorded per distinct change.
- Simultaneous push and pop:
  - When full: both happen, count is unchanged, no overflow.
  - When empty: only the push happens, since rd_valid=0.
- count: +1 on push only, -1 on pop only, unchanged on both or neither. It never exceeds DEPTH and never goes below 0.
- Pointers are AW bits and wrap modulo DEPTH. Full and empty are derived from count.
- overflow: clr_ovf=1 clears it. A new drop in the same cycle as clr_ovf wins, and overflow stays 1.
- rd_ready while rd_valid=0 has no effect.

Optional Feature:
- Macro: CAP_TIMESTAMP_EN.
- Defined:
  - A free-running TSW-bit cycle counter runs from reset; it counts in all states and wraps to 0 after 2^TSW-1.
  - Each push stores the counter value at the push edge alongside the data.
  - Extra output port `rd_ts` (out, TSW) gives the head entry's timestamp and changes together with rd_data.
- Undefined: no counter, no `rd_ts` port, no timestamp storage.

Test Plan:
- Reset, then cap_en=1 with z_in held 8'h00 for 10 cycles -> exactly 1 entry (00); count=1; rd_valid=1 two edges after cap_en rises.
- cap_en=1; z_in sequence 05,05,07,07,07,09 with rd_ready=0 -> entries 05,07,09 in order; count=3; repeated values are not stored.
- DEPTH=16, rd_ready=0; z_in increments every cycle for 20 cycles -> count=16 and overflow=1; pulse clr_ovf -> overflow=0. Entries 00..0F are readable in order.
- FIFO full with rd_ready=1 and a new z_in value in the same cycle -> count stays 16, overflow stays 0, head advances by one.
- Drive rst=0 asynchronously mid-stream with count=5 -> rd_valid=0 and count=0 immediately, with no clock edge needed. After release and cap_en=1, the first entry equals the current z_in.
- With CAP_TIMESTAMP_EN and TSW=4: pushes at cycles 3 and 20 -> rd_ts reads 3, then 4 (20 mod 16).

Source files
------------

// File: rtl/cpu_out_capture.sv
// =============================================================================
// Module   : cpu_out_capture
// Purpose  : Records each new value of the CPU z output in a FIFO and serves it
//            on a valid/ready read port. Optional macro: CAP_TIMESTAMP_EN.
// Revision : 1.0
// =============================================================================
`default_nettype none

module cpu_out_capture #(
  parameter int DEPTH = 16,
  parameter int AW    = 4,
  parameter int TSW   = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [7:0]    z_in,
  input  logic          cap_en,
  input  logic          rd_ready,
  output logic          rd_valid,
  output logic [7:0]    rd_data,
  output logic [AW:0]   count,
  output logic          overflow,
  input  logic          clr_ovf
`ifdef CAP_TIMESTAMP_EN
  ,
  output logic [TSW-1:0] rd_ts
`endif
);

  localparam logic [AW:0] C_FULL = (AW + 1)'(DEPTH);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PRIME = 2'd1,
    TRACK = 2'd2
  } state_t;

  state_t        r_state, w_next;
  logic [7:0]    r_last_z;
  logic [AW-1:0] r_wr_ptr, r_rd_ptr;
  logic [AW:0]   r_count;
  logic          r_ovf;
  logic [7:0]    r_mem [DEPTH];

  logic w_push, w_pop, w_full, w_do_push, w_drop;

  generate
    if ((AW != $clog2(DEPTH)) || (DEPTH < 2) || (TSW < 1)) begin : g_param_check
      $error("cpu_out_capture: inconsistent DEPTH/AW/TSW");
    end
  endgenerate

  always_comb begin
    w_next = r_state;
    w_push = 1'b0;
    case (r_state)
      IDLE:  if (cap_en) w_next = PRIME;
      PRIME: begin
        if (cap_en) begin
          w_push = 1'b1;
          w_next = TRACK;
        end else begin
          w_next = IDLE;
        end
      end
      TRACK: begin
        if (!cap_en) w_next = IDLE;
        else         w_push = (z_in != r_last_z);
      end
      default: w_next = IDLE;
    endcase
  end

  assign w_full    = (r_count == C_FULL);
  assign w_pop     = rd_valid & rd_ready;
  // A full FIFO still accepts a push when the head leaves on the same edge.
  assign w_do_push = w_push & (~w_full | w_pop);
  assign w_drop    = w_push & w_full & ~w_pop;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state  <= IDLE;
      r_last_z <= 8'h00;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_ovf    <= 1'b0;
    end else begin
      r_state  <= w_next;
      r_last_z <= z_in;
      if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)     r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_do_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
      if (w_drop)       r_ovf <= 1'b1;
      else if (clr_ovf) r_ovf <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_ptr] <= z_in;
  end

  assign rd_valid = (r_count != '0);
  assign rd_data  = rd_valid ? r_mem[r_rd_ptr] : 8'h00;
  assign count    = r_count;
  assign overflow = r_ovf;

`ifdef CAP_TIMESTAMP_EN
  logic [TSW-1:0] r_ts;
  logic [TSW-1:0] r_ts_mem [DEPTH];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_ts <= '0;
    else      r_ts <= r_ts + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (w_do_push) r_ts_mem[r_wr_ptr] <= r_ts;
  end

  assign rd_ts = rd_valid ? r_ts_mem[r_rd_ptr] : '0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_cpu_out_capture.sv
// Directed vector table plus hand-written sequences for cpu_out_capture.
`default_nettype none

module tb_cpu_out_capture;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] z_in;
  logic       cap_en, rd_ready, clr_ovf;
  logic       rd_valid, overflow;
  logic [7:0] rd_data;
  logic [4:0] count;
`ifdef CAP_TIMESTAMP_EN
  logic [15:0] rd_ts;
`endif

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  cpu_out_capture #(.DEPTH(16), .AW(4), .TSW(16)) dut (
    .clk      (clk),
    .rst      (rst),
    .z_in     (z_in),
    .cap_en   (cap_en),
    .rd_ready (rd_ready),
    .rd_valid (rd_valid),
    .rd_data  (rd_data),
    .count    (count),
    .overflow (overflow),
    .clr_ovf  (clr_ovf)
`ifdef CAP_TIMESTAMP_EN
    ,
    .rd_ts    (rd_ts)
`endif
  );

  typedef struct {
    logic [7:0] z;
    logic       cap;
    logic       rdy;
    logic       clr;
    logic       e_valid;
    logic [7:0] e_data;
    logic [4:0] e_count;
    logic       e_ovf;
  } vec_t;

  vec_t vec [23];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic reset_dut();
    rst = 1'b0; z_in = 8'h00; cap_en = 1'b0; rd_ready = 1'b0; clr_ovf = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
  endtask

  initial begin
    //            z      cap   rdy   clr   valid e_data  cnt    ovf
    vec[0]  = '{8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 5'd0, 1'b0};
    vec[1]  = '{8'h00, 1'b1, 1'b0, 1'b0, 1'b1, 8'h00, 5'd1, 1'b0};
    vec[2]  = '{8'h00, 1'b1, 1'b0, 1'b0, 1'b1, 8'h00, 5'd1, 1'b0};
    vec[3]  = '{8'h00, 1'b1, 1'b0, 1'b0, 1'b1, 8'h00, 5'd1, 1'b0};
    vec[4]  = '{8'h05, 1'b1, 1'b0, 1'b0, 1'b1, 8'h00, 5'd2, 1'b0};
    vec[5]  = '{8'h05, 1'b1, 1'b0, 1'b0, 1'b1, 8'h00, 5'd2, 1'b0};
    vec[6]  = '{8'h07, 1'b1, 1'b0, 1'b0, 1'b1, 8'h00, 5'd3, 1'b0};
    vec[7]  = '{8'h07, 1'b1, 1'b0, 1'b0, 1'b1, 8'h00, 5'd3, 1'b0};
    vec[8]  = '{8'h07, 1'b1, 1'b0, 1'b0, 1'b1, 8'h00, 5'd3, 1'b0};
    vec[9]  = '{8'h09, 1'b1, 1'b0, 1'b0, 1'b1, 8'h00, 5'd4, 1'b0};
    vec[10] = '{8'h09, 1'b1, 1'b1, 1'b0, 1'b1, 8'h05, 5'd3, 1'b0};
    vec[11] = '{8'h09, 1'b1, 1'b1, 1'b0, 1'b1, 8'h07, 5'd2, 1'b0};
    vec[12] = '{8'h09, 1'b1, 1'b1, 1'b0, 1'b1, 8'h09, 5'd1, 1'b0};
    vec[13] = '{8'h09, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 5'd0, 1'b0};
    vec[14] = '{8'h09, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 5'd0, 1'b0};
    vec[15] = '{8'h0A, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 5'd0, 1'b0};
    vec[16] = '{8'h0A, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 5'd0, 1'b0};
    vec[17] = '{8'h0A, 1'b1, 1'b0, 1'b0, 1'b1, 8'h0A, 5'd1, 1'b0};
    vec[18] = '{8'h0B, 1'b1, 1'b1, 1'b0, 1'b1, 8'h0B, 5'd1, 1'b0};
    vec[19] = '{8'h0B, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 5'd0, 1'b0};
    vec[20] = '{8'h0C, 1'b1, 1'b1, 1'b0, 1'b1, 8'h0C, 5'd1, 1'b0};
    vec[21] = '{8'h0C, 1'b0, 1'b0, 1'b0, 1'b1, 8'h0C, 5'd1, 1'b0};
    vec[22] = '{8'h0C, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 5'd0, 1'b0};

    // Reset state
    reset_dut();
    check("reset_valid", 32'(rd_valid), 32'd0);
    check("reset_data",  32'(rd_data),  32'h00);
    check("reset_count", 32'(count),    32'd0);
    check("reset_ovf",   32'(overflow), 32'd0);

    // Table: priming, change detection, pops, re-enable, push/pop mixes
    for (int i = 0; i < 23; i++) begin
      z_in = vec[i].z; cap_en = vec[i].cap; rd_ready = vec[i].rdy; clr_ovf = vec[i].clr;
      step();
      check($sformatf("vec%0d_valid", i), 32'(rd_valid), 32'(vec[i].e_valid));
      check($sformatf("vec%0d_data",  i), 32'(rd_data),  32'(vec[i].e_data));
      check($sformatf("vec%0d_count", i), 32'(count),    32'(vec[i].e_count));
      check($sformatf("vec%0d_ovf",   i), 32'(overflow), 32'(vec[i].e_ovf));
    end

    // Fill past full: 20 distinct values, 16 stored, overflow set
    reset_dut();
    cap_en = 1'b1;
    step();
    for (int i = 0; i < 20; i++) begin
      z_in = 8'(i);
      step();
      check($sformatf("fill%0d_count", i), 32'(count), (i < 16) ? 32'(i + 1) : 32'd16);
    end
    check("fill_ovf", 32'(overflow), 32'd1);

    // Drop in the same cycle as clear: drop wins
    z_in = 8'h20; clr_ovf = 1'b1;
    step();
    check("clr_vs_drop_ovf", 32'(overflow), 32'd1);
    check("clr_vs_drop_count", 32'(count), 32'd16);
    step();
    clr_ovf = 1'b0;
    check("clr_ovf", 32'(overflow), 32'd0);
    check("full_head", 32'(rd_data), 32'h00);

    // Full with simultaneous pop and push
    rd_ready = 1'b1; z_in = 8'h21;
    step();
    check("full_pushpop_count", 32'(count), 32'd16);
    check("full_pushpop_ovf", 32'(overflow), 32'd0);
    for (int k = 1; k < 16; k++) begin
      check($sformatf("drain%0d_data", k), 32'(rd_data), 32'(k));
      step();
    end
    check("drain_last_data", 32'(rd_data), 32'h21);
    step();
    check("drain_empty_count", 32'(count), 32'd0);
    check("drain_empty_valid", 32'(rd_valid), 32'd0);

    // Asynchronous reset mid-stream
    reset_dut();
    cap_en = 1'b1; z_in = 8'h30;
    step();
    for (int i = 0; i < 5; i++) begin
      z_in = 8'h30 + 8'(i);
      step();
    end
    check("pre_areset_count", 32'(count), 32'd5);
    #2 rst = 1'b0;
    #1;
    check("areset_valid", 32'(rd_valid), 32'd0);
    check("areset_count", 32'(count), 32'd0);
    @(posedge clk);
    #1 rst = 1'b1; z_in = 8'h77; cap_en = 1'b1;
    step();
    check("rearm_prime_count", 32'(count), 32'd0);
    step();
    check("rearm_valid", 32'(rd_valid), 32'd1);
    check("rearm_data", 32'(rd_data), 32'h77);
    check("rearm_count", 32'(count), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
